// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int unsigned DIV_ITER  = 32;
  localparam int unsigned DIV_CNT_W = 6;

  // Two's-complement negate when neg is set; also yields the magnitude of a negative value.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit into the dividend.
module div_step (
  input  logic [31:0] i_rem,
  input  logic [31:0] i_dvd,
  input  logic [31:0] i_dvs,
  output logic [31:0] o_rem,
  output logic [31:0] o_dvd,
  output logic        o_qbit
);

  logic [32:0] w_shift;
  logic [31:0] w_diff;

  assign w_shift = {i_rem, i_dvd[31]};
  assign o_qbit  = (w_shift >= {1'b0, i_dvs});
  // When the subtraction succeeds the true difference is below the divisor, so 32 bits suffice.
  assign w_diff  = w_shift[31:0] - i_dvs;
  assign o_rem   = o_qbit ? w_diff : w_shift[31:0];
  assign o_dvd   = {i_dvd[30:0], o_qbit};

endmodule

// File: rtl/divider.sv
// Iterative 32-bit signed/unsigned divider with fixed latency, result backpressure,
// flush and an optional single-cycle divide-by-zero path.
module divider
  import divider_pkg::*;
#(
  parameter int unsigned DIV_FAST_ZERO = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        div_valid_i,
  output logic        div_ready_o,
  input  logic        div_signed_i,
  input  logic [31:0] X_i,
  input  logic [31:0] Y_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] q_o,
  output logic [31:0] r_o,
  output logic        busy_o
);

  localparam logic [DIV_CNT_W-1:0] CntLast = DIV_CNT_W'(DIV_ITER - 1);

  div_state_e           r_state;
  logic [DIV_CNT_W-1:0] r_cnt;
  logic [31:0]          r_rem;
  logic [31:0]          r_dvd;
  logic [31:0]          r_dvs;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_dvs_zero;
  logic [31:0]          r_q;
  logic [31:0]          r_r;

  logic        w_x_neg;
  logic        w_y_neg;
  logic        w_y_zero;
  logic [31:0] w_step_rem;
  logic [31:0] w_step_dvd;
  logic        w_step_qbit;

  assign w_x_neg  = div_signed_i & X_i[31];
  assign w_y_neg  = div_signed_i & Y_i[31];
  assign w_y_zero = (Y_i == 32'd0);

  div_step u_step (
    .i_rem  (r_rem),
    .i_dvd  (r_dvd),
    .i_dvs  (r_dvs),
    .o_rem  (w_step_rem),
    .o_dvd  (w_step_dvd),
    .o_qbit (w_step_qbit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dvs_zero <= 1'b0;
      r_q        <= '0;
      r_r        <= '0;
    end else if (flush_i) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (div_valid_i) begin
            r_neg_q    <= w_x_neg ^ w_y_neg;
            r_neg_r    <= w_x_neg;
            r_dvs_zero <= w_y_zero;
            r_dvd      <= cond_neg(X_i, w_x_neg);
            r_dvs      <= cond_neg(Y_i, w_y_neg);
            r_rem      <= '0;
            r_cnt      <= '0;
            if (w_y_zero && (DIV_FAST_ZERO != 0)) begin
              r_q     <= '1;
              r_r     <= X_i;
              r_state <= DONE;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_step_rem;
          r_dvd <= w_step_dvd;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CntLast) begin
            // A zero divisor yields all-ones; the remainder path already reproduces X.
            r_q     <= r_dvs_zero ? '1 : cond_neg(w_step_dvd, r_neg_q);
            r_r     <= cond_neg(w_step_rem, r_neg_r);
            r_state <= DONE;
          end
        end
        DONE: begin
          if (res_ready_i) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign div_ready_o = (r_state == IDLE);
  assign res_valid_o = (r_state == DONE);
  assign busy_o      = (r_state != IDLE);
  assign q_o         = r_q;
  assign r_o         = r_r;

endmodule
